// File: rtl/conv_out_streamer_pkg.sv
// conv_out_streamer_pkg
//   Shared definitions for the conv output streamer family: output-geometry
//   helpers (same formulas the conv layer uses), index-width helper and the
//   streamer FSM encoding.
package conv_out_streamer_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Output dimension of a valid (unpadded) convolution.
  function automatic int out_dim(input int n, input int f, input int s);
    return (n - f) / s + 1;
  endfunction

  // Index width for a count of n items; never narrower than one bit so that
  // degenerate 1x1 geometries still produce legal vectors.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_out_if.sv
// conv_out_if
//   Bundles the frame-in handshake and the pixel-out stream of the streamer.
//   master : the streamer itself (drives in_ready and the pixel stream)
//   slave  : the surroundings (frame producer and pixel consumer)
//   Signals: in_valid/in_ready/in_frame  frame handshake, pixel 0 at MSB end
//            out_valid/out_ready         pixel handshake
//            out_data/out_row/out_col    current pixel and its position
//            out_last_col/out_last       end-of-row / end-of-frame markers
interface conv_out_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NPIX       = 1,
  parameter int RW         = 1,
  parameter int CW         = 1
);
  logic                         in_valid;
  logic                         in_ready;
  logic [0:NPIX*DATA_WIDTH-1]   in_frame;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [RW-1:0]                out_row;
  logic [CW-1:0]                out_col;
  logic                         out_last_col;
  logic                         out_last;

  modport master (
    input  in_valid, in_frame, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col, out_last_col, out_last
  );

  modport slave (
    output in_valid, in_frame, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col, out_last_col, out_last
  );
endinterface

// File: rtl/conv_out_index_counter.sv
// conv_out_index_counter
//   Row-major row/col counter over a ROWS x COLS grid.
//   clk, reset : clock, synchronous active-high reset (counters to 0)
//   clr        : return to (0,0)
//   en         : advance one position; wraps to (0,0) after the last one
//   row, col   : current position (registered)
//   last_col   : col == COLS-1
//   last       : final position of the grid
module conv_out_index_counter
  import conv_out_streamer_pkg::*;
#(
  parameter  int ROWS = 4,
  parameter  int COLS = 4,
  localparam int RW   = idx_w(ROWS),
  localparam int CW   = idx_w(COLS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last_col,
  output logic          last
);

  assign last_col = (col == CW'(COLS - 1));
  assign last     = last_col && (row == RW'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (last_col) begin
        col <= '0;
        row <= last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_out_streamer.sv
// conv_out_streamer
//   Captures one complete conv output frame in a single cycle, then streams
//   it row-major one pixel per out_valid/out_ready handshake, tagging row and
//   frame ends. One bubble cycle separates consecutive frames.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : conv_out_if master (frame in, pixel stream out)
module conv_out_streamer
  import conv_out_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5,
  parameter int s          = 1
) (
  input  logic       clk,
  input  logic       reset,
  conv_out_if.master bus
);

  localparam int OH   = out_dim(H, F, s);
  localparam int OW   = out_dim(W, F, s);
  localparam int NPIX = OH * OW;
  localparam int IDXW = idx_w(NPIX);
  localparam int RW   = idx_w(OH);
  localparam int CW   = idx_w(OW);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] buf_q [NPIX];
  logic [RW-1:0]         cnt_row;
  logic [CW-1:0]         cnt_col;
  logic                  cnt_last_col, cnt_last;
  logic [IDXW-1:0]       pix_idx;
  logic                  accept, fire;

  // Everything the outputs depend on is registered; in_valid/out_ready only
  // steer the next state, never the current outputs.
  assign accept  = (state_q == IDLE) && bus.in_valid;
  assign fire    = (state_q == STREAM) && bus.out_ready;
  assign pix_idx = IDXW'(cnt_row) * IDXW'(OW) + IDXW'(cnt_col);

  conv_out_index_counter #(
    .ROWS (OH),
    .COLS (OW)
  ) u_idx (
    .clk      (clk),
    .reset    (reset),
    .clr      (accept),
    .en       (fire),
    .row      (cnt_row),
    .col      (cnt_col),
    .last_col (cnt_last_col),
    .last     (cnt_last)
  );

  // Frame capture: the accept cycle is the only time in_frame is sampled.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NPIX; k++) begin
        buf_q[k] <= bus.in_frame[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)         state_d = STREAM;
      STREAM:  if (fire && cnt_last)     state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // Flags and data are gated by STREAM so the idle bus reads all-zero even
  // for 1-wide geometries where the raw counter flags sit at 1.
  always_comb begin
    bus.in_ready     = 1'b0;
    bus.out_valid    = 1'b0;
    bus.out_data     = '0;
    bus.out_row      = cnt_row;
    bus.out_col      = cnt_col;
    bus.out_last_col = 1'b0;
    bus.out_last     = 1'b0;
    if (state_q == IDLE) begin
      bus.in_ready = 1'b1;
    end else begin
      bus.out_valid    = 1'b1;
      bus.out_data     = buf_q[pix_idx];
      bus.out_last_col = cnt_last_col;
      bus.out_last     = cnt_last;
    end
  end

endmodule

// File: tb/tb_conv_out_streamer.sv
module tb_conv_out_streamer;
  import conv_out_streamer_pkg::*;

  localparam int A_OH   = out_dim(6, 3, 1);
  localparam int A_OW   = out_dim(6, 3, 1);
  localparam int A_NPIX = A_OH * A_OW;
  localparam int B_NPIX = out_dim(5, 5, 1) * out_dim(5, 5, 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_out_if #(.DATA_WIDTH(16), .NPIX(A_NPIX), .RW(idx_w(A_OH)), .CW(idx_w(A_OW))) ia ();
  conv_out_if #(.DATA_WIDTH(16), .NPIX(B_NPIX), .RW(1), .CW(1)) ib ();

  conv_out_streamer #(.DATA_WIDTH(16), .H(6), .W(6), .F(3), .s(1)) dut_a (
    .clk(clk), .reset(rst), .bus(ia.master));
  conv_out_streamer #(.DATA_WIDTH(16), .H(5), .W(5), .F(5), .s(1)) dut_b (
    .clk(clk), .reset(rst), .bus(ib.master));

  int checks = 0;
  int errors = 0;
  logic [15:0] bus_a [A_NPIX];
  logic [15:0] exp_a [A_NPIX];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive a frame onto the A bus: pixel k = base+k, or random when rnd.
  task automatic drive_a(input logic [15:0] base, input bit rnd);
    for (int k = 0; k < A_NPIX; k++) begin
      bus_a[k] = rnd ? 16'($urandom) : base + 16'(k);
      ia.in_frame[k*16 +: 16] = bus_a[k];
    end
  endtask

  task automatic latch_expect_a();
    for (int k = 0; k < A_NPIX; k++) exp_a[k] = bus_a[k];
  endtask

  // Reference: beat k carries exp_a[k] at (k/OW, k%OW); row end when
  // k%OW==OW-1, frame end at k==NPIX-1. Outputs are checked every cycle,
  // so stalled cycles must show the same beat again.
  task automatic drain_a(input int mode, input int stop_after);
    int k = 0;
    int cyc = 0;
    bit r;
    while (k < stop_after && cyc < 400) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      ia.out_ready = r;
      chk("out_valid", 32'(ia.out_valid), 1);
      chk("in_ready_busy", 32'(ia.in_ready), 0);
      chk("out_data", 32'(ia.out_data), 32'(exp_a[k]));
      chk("out_row", 32'(ia.out_row), k / A_OW);
      chk("out_col", 32'(ia.out_col), k % A_OW);
      chk("out_last_col", 32'(ia.out_last_col), 32'((k % A_OW) == A_OW - 1));
      chk("out_last", 32'(ia.out_last), 32'(k == A_NPIX - 1));
      if (r) k++;
      tick();
      cyc++;
    end
    chk("beat_count", k, stop_after);
    ia.out_ready = 1'b0;
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, "_in_ready"}, 32'(ia.in_ready), 1);
    chk({tag, "_out_valid"}, 32'(ia.out_valid), 0);
    chk({tag, "_out_data"}, 32'(ia.out_data), 0);
    chk({tag, "_out_row"}, 32'(ia.out_row), 0);
    chk({tag, "_out_col"}, 32'(ia.out_col), 0);
    chk({tag, "_last_col"}, 32'(ia.out_last_col), 0);
    chk({tag, "_last"}, 32'(ia.out_last), 0);
  endtask

  initial begin
    rst = 1'b1;
    ia.in_valid = 1'b0; ia.out_ready = 1'b0; ia.in_frame = '0;
    ib.in_valid = 1'b0; ib.out_ready = 1'b0; ib.in_frame = '0;
    tick();
    tick();
    chk_idle_a("reset");
    chk("reset_b_in_ready", 32'(ib.in_ready), 1);
    chk("reset_b_out_valid", 32'(ib.out_valid), 0);
    chk("reset_b_last_col", 32'(ib.out_last_col), 0);
    chk("reset_b_last", 32'(ib.out_last), 0);
    rst = 1'b0;
    tick();

    // Incrementing frame, continuous ready.
    drive_a(16'h0100, 1'b0);
    latch_expect_a();
    ia.in_valid = 1'b1;
    tick();
    ia.in_valid = 1'b0;
    drain_a(0, A_NPIX);
    chk_idle_a("after_frame1");

    // Same frame with 1,0,0,1 ready pattern.
    ia.in_valid = 1'b1;
    tick();
    ia.in_valid = 1'b0;
    drain_a(1, A_NPIX);
    chk_idle_a("after_pattern");

    // Random frame, random ready.
    drive_a(16'h0000, 1'b1);
    latch_expect_a();
    ia.in_valid = 1'b1;
    tick();
    ia.in_valid = 1'b0;
    drain_a(2, A_NPIX);
    chk_idle_a("after_random");

    // in_valid held with a new frame while streaming.
    drive_a(16'h0100, 1'b0);
    latch_expect_a();
    ia.in_valid = 1'b1;
    tick();
    drive_a(16'h0200, 1'b0);
    drain_a(0, A_NPIX);
    chk("bubble_in_ready", 32'(ia.in_ready), 1);
    chk("bubble_out_valid", 32'(ia.out_valid), 0);
    latch_expect_a();
    tick();
    ia.in_valid = 1'b0;
    drain_a(0, A_NPIX);
    chk_idle_a("after_frame2");

    // Reset after the 5th transfer aborts the frame.
    drive_a(16'h0000, 1'b1);
    latch_expect_a();
    ia.in_valid = 1'b1;
    tick();
    ia.in_valid = 1'b0;
    drain_a(0, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_a("mid_reset");
    drive_a(16'h0300, 1'b0);
    latch_expect_a();
    ia.in_valid = 1'b1;
    tick();
    ia.in_valid = 1'b0;
    drain_a(0, A_NPIX);
    chk_idle_a("after_frame3");

    // reset and in_valid together: frame not taken.
    rst = 1'b1;
    ia.in_valid = 1'b1;
    tick();
    rst = 1'b0;
    ia.in_valid = 1'b0;
    chk_idle_a("rst_vs_valid");
    tick();
    chk("rst_vs_valid_later", 32'(ia.out_valid), 0);

    // Single-pixel geometry.
    ib.in_frame = 16'hBEEF;
    ib.in_valid = 1'b1;
    tick();
    ib.in_valid = 1'b0;
    chk("b_out_valid", 32'(ib.out_valid), 1);
    chk("b_in_ready", 32'(ib.in_ready), 0);
    chk("b_data", 32'(ib.out_data), 32'h0000BEEF);
    chk("b_last_col", 32'(ib.out_last_col), 1);
    chk("b_last", 32'(ib.out_last), 1);
    tick();
    chk("b_hold_valid", 32'(ib.out_valid), 1);
    chk("b_hold_data", 32'(ib.out_data), 32'h0000BEEF);
    ib.out_ready = 1'b1;
    tick();
    ib.out_ready = 1'b0;
    chk("b_done_valid", 32'(ib.out_valid), 0);
    chk("b_done_in_ready", 32'(ib.in_ready), 1);
    chk("b_done_last", 32'(ib.out_last), 0);
    chk("b_done_last_col", 32'(ib.out_last_col), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_out_streamer.md
Name: conv_out_streamer

Overview:
- Drains one complete convolution output frame (flat row-major bus from a conv layer) and emits it one pixel per handshake on a valid/ready stream.
- Sits between a conv layer's outputConv bus and downstream serial consumers (pooling, activation, DMA/FIFO to host).
- Captures the frame in one cycle, then streams row-major with row-end and frame-end markers; backpressure-safe.

Parameters:
- DATA_WIDTH, 16, pixel width in bits (fixed-point, passed through untouched)
- H, 32, input image height seen by the conv layer
- W, 32, input image width seen by the conv layer
- F, 5, filter size
- s, 1, stride
- Derived (localparam): OH = (H-F)/s+1, OW = (W-F)/s+1, NPIX = OH*OW, IDXW = clog2(NPIX)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- in_valid  input  1  frame on in_frame is complete and valid
- in_ready  output  1  block can accept a frame this cycle
- in_frame  input  [0:NPIX*DATA_WIDTH-1]  flat frame; pixel k at bits [k*DATA_WIDTH +: DATA_WIDTH], row-major, pixel 0 at MSB end
- out_valid  output  1  out_data holds a valid pixel
- out_ready  input  1  downstream accepts pixel
- out_data  output  DATA_WIDTH  current pixel
- out_row  output  clog2(OH)  row index of current pixel
- out_col  output  clog2(OW)  column index of current pixel
- out_last_col  output  1  current pixel is last of its row (col == OW-1)
- out_last  output  1  current pixel is last of frame (row == OH-1, col == OW-1)

Behaviour:
- Clock clk, reset synchronous active-high; all state updates on posedge clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_row=0, out_col=0, out_last_col=0, out_last=0, frame buffer contents don't-care.
- FSM states: IDLE, STREAM.
- IDLE: in_ready=1, out_valid=0. On in_valid=1: latch entire in_frame into internal buffer, row=0, col=0, go STREAM. Accept cycle is the only cycle in_frame is sampled.
- STREAM: in_ready=0; in_valid ignored (frame not consumed, upstream must hold). out_valid=1 from the cycle after acceptance (latency 1 clk from accept to first pixel).
- out_data = buffer pixel (row*OW+col); out_row/out_col/out_last_col/out_last registered or derived from registered counters only (no combinational path from in_* or out_ready to outputs).
- Handshake: pixel transfers when out_valid && out_ready. Without transfer, out_data/out_row/out_col/flags hold stable.
- On transfer: col==OW-1 -> col=0, row=row+1; else col=col+1. On transfer with out_last=1 -> state=IDLE, out_valid=0 next cycle, counters=0.
- Next frame: in_ready=1 in cycle after last transfer; one bubble cycle between frames (no same-cycle reload).
- Throughput: one pixel/clk under continuous out_ready; frame takes NPIX cycles + 1 accept + 1 bubble.
- Reset mid-stream: abort immediately; outputs return to reset values next edge; partial frame discarded.
- reset and in_valid same cycle: reset wins, frame not accepted.
- Degenerate OH or OW = 1: out_last_col asserted every pixel (OW=1), out_last on final pixel; NPIX=1 streams exactly one beat with out_last_col=out_last=1.
- No arithmetic on data; width preserved bit-exact.

Decomposition:
- Shared package: DATA_WIDTH, derived OH/OW/NPIX expressions and clog2 helper (same formulas conv layer uses), FSM state encoding.
- One natural sub-module: conv_out_index_counter (row/col counters with enable, wrap, last_col/last flags), reusable by future pooling streamers.

Test Plan:
- Params H=6,W=6,F=3,s=1 (OH=OW=4); frame pixel k = 16'h0100+k, out_ready=1 -> 16 beats 0x0100..0x010F in order, out_last_col on k=3,7,11,15, out_last only on k=15, in_ready high cycle after.
- Same frame, out_ready toggled 1,0,0,1 pattern -> identical data sequence; out_data/out_row/out_col stable during every stalled cycle.
- in_valid held high with new frame (0x0200+k) during STREAM -> in_ready=0, first frame completes unchanged, second frame accepted cycle after out_last transfer, one bubble.
- reset asserted after 5th transfer -> next cycle out_valid=0, in_ready=1; new frame 0x0300+k streams from pixel 0.
- reset and in_valid same cycle -> frame not accepted, out_valid stays 0.
- Params H=W=5,F=5 (NPIX=1), pixel 16'hBEEF -> single beat with out_last_col=out_last=1, then IDLE.
